// File: rtl/pipeline_hazard_ctrl.sv
// Hazard/stall controller: per-latch enable and flush vectors plus PC enable,
// with load-use bubbles, pending branch redirect, multi-cycle execute stall and sticky halt.
module pipeline_hazard_ctrl #(
    parameter int STAGES       = 4,
    parameter int REGW         = 5,
    parameter int BR_STAGE     = 2,
    parameter int MEM_STAGE    = 2,
    parameter int MULTI_CYCLES = 4
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              ihit,
    input  logic              dhit,
    input  logic              mem_req,
    input  logic              halt_in,
    input  logic              br_taken,
    input  logic [REGW-1:0]   id_rs,
    input  logic [REGW-1:0]   id_rt,
    input  logic [REGW-1:0]   ex_rd,
    input  logic              ex_memread,
    input  logic              multi_start,
    output logic [STAGES-1:0] en,
    output logic [STAGES-1:0] flush,
    output logic              pc_en,
    output logic              halted
);

    localparam logic [3:0] MC_LOAD = 4'(MULTI_CYCLES - 1);

    logic              halted_q, halted_d;
    logic [3:0]        mcnt_q, mcnt_d;
    logic              br_pend_q, br_pend_d;
    logic [STAGES-1:0] br_mask, mem_lo_mask, mem_onehot;
    logic [STAGES-1:0] en_c, flush_c;
    logic              pc_en_c;
    logic              dfreeze, mbusy, lu;

    // Static per-latch masks derived from the stage indices.
    genvar gi;
    generate
        for (gi = 0; gi < STAGES; gi++) begin : g_mask
            assign br_mask[gi]     = (gi < BR_STAGE);
            assign mem_lo_mask[gi] = (gi < MEM_STAGE);
            assign mem_onehot[gi]  = (gi == MEM_STAGE);
        end
    endgenerate

    assign dfreeze = mem_req & ~dhit;
    assign mbusy   = (mcnt_q != 4'd0);
    assign lu      = ex_memread & (ex_rd != '0) & ((ex_rd == id_rs) | (ex_rd == id_rt));

    always_comb begin
        en_c      = '0;
        flush_c   = '0;
        pc_en_c   = 1'b0;
        br_pend_d = br_pend_q;
        halted_d  = halted_q;
        mcnt_d    = mcnt_q;

        if (halted_q) begin
            // everything held off until reset
        end else if (dfreeze) begin
            if (br_taken) br_pend_d = 1'b1;
        end else if (mbusy) begin
            en_c    = ~mem_lo_mask;
            flush_c = mem_onehot;
            if (br_taken) br_pend_d = 1'b1;
        end else if (br_taken || br_pend_q) begin
            en_c      = '1;
            flush_c   = br_mask;
            pc_en_c   = 1'b1;
            br_pend_d = 1'b0;
        end else if (lu) begin
            en_c    = {{(STAGES-1){1'b1}}, 1'b0};
            flush_c = STAGES'(2);
        end else if (!ihit) begin
            en_c    = '1;
            flush_c = STAGES'(1);
        end else begin
            en_c    = '1;
            pc_en_c = 1'b1;
        end

        if (halt_in && !dfreeze) halted_d = 1'b1;

        // Counter only moves when memory is not frozen; a start while busy is dropped.
        if (!dfreeze) begin
            if (mcnt_q == 4'd0) begin
                if (multi_start) mcnt_d = MC_LOAD;
            end else begin
                mcnt_d = mcnt_q - 4'd1;
            end
        end
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            halted_q  <= 1'b0;
            mcnt_q    <= 4'd0;
            br_pend_q <= 1'b0;
        end else begin
            halted_q  <= halted_d;
            mcnt_q    <= mcnt_d;
            br_pend_q <= br_pend_d;
        end
    end

    assign en     = RST ? '0 : en_c;
    assign flush  = RST ? '0 : flush_c;
    assign pc_en  = RST ? 1'b0 : pc_en_c;
    assign halted = halted_q;

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Directed testbench for pipeline_hazard_ctrl: combinational vector table from idle
// state, then hand-written multi-cycle sequences (data miss, multi-cycle op, halt/reset).
module tb_pipeline_hazard_ctrl;

    logic       CLK, RST;
    logic       ihit, dhit, mem_req, halt_in, br_taken, ex_memread, multi_start;
    logic [4:0] id_rs, id_rt, ex_rd;
    logic [3:0] en, flush;
    logic       pc_en, halted;

    int passed = 0;
    int total  = 0;

    pipeline_hazard_ctrl dut (
        .CLK(CLK), .RST(RST), .ihit(ihit), .dhit(dhit), .mem_req(mem_req),
        .halt_in(halt_in), .br_taken(br_taken), .id_rs(id_rs), .id_rt(id_rt),
        .ex_rd(ex_rd), .ex_memread(ex_memread), .multi_start(multi_start),
        .en(en), .flush(flush), .pc_en(pc_en), .halted(halted)
    );

    initial begin
        CLK = 1'b0;
        forever #5 CLK = ~CLK;
    end

    typedef struct {
        string      name;
        logic       ihit, dhit, mem_req, br_taken, ex_memread;
        logic [4:0] id_rs, id_rt, ex_rd;
        logic [3:0] e_en, e_flush;
        logic       e_pc;
    } vec_t;

    vec_t vecs[12];

    task automatic idle();
        ihit = 1'b1; dhit = 1'b0; mem_req = 1'b0; halt_in = 1'b0; br_taken = 1'b0;
        ex_memread = 1'b0; multi_start = 1'b0; id_rs = 5'd0; id_rt = 5'd0; ex_rd = 5'd0;
    endtask

    task automatic check(input string name, input logic [3:0] e_en, input logic [3:0] e_fl,
                         input logic e_pc, input logic e_h);
        total++;
        if (en === e_en && flush === e_fl && pc_en === e_pc && halted === e_h) begin
            passed++;
            $display("ok   %s: en=%b flush=%b pc_en=%b halted=%b", name, en, flush, pc_en, halted);
        end else begin
            $display("FAIL %s: got en=%b flush=%b pc_en=%b halted=%b, want en=%b flush=%b pc_en=%b halted=%b",
                     name, en, flush, pc_en, halted, e_en, e_fl, e_pc, e_h);
        end
    endtask

    // Advance to the next falling edge, where inputs are driven.
    task automatic step();
        @(negedge CLK);
    endtask

    initial begin
        //          name          ihit dhit mreq br  mrd rs    rt    rd    en       flush    pc
        vecs[0]  = '{"idle",       1, 0, 0, 0, 0, 5'd0, 5'd0, 5'd0, 4'b1111, 4'b0000, 1};
        vecs[1]  = '{"lu_rt",      1, 0, 0, 0, 1, 5'd3, 5'd8, 5'd8, 4'b1110, 4'b0010, 0};
        vecs[2]  = '{"lu_rs",      1, 0, 0, 0, 1, 5'd9, 5'd4, 5'd9, 4'b1110, 4'b0010, 0};
        vecs[3]  = '{"lu_rd0",     1, 0, 0, 0, 1, 5'd0, 5'd0, 5'd0, 4'b1111, 4'b0000, 1};
        vecs[4]  = '{"no_load",    1, 0, 0, 0, 0, 5'd8, 5'd8, 5'd8, 4'b1111, 4'b0000, 1};
        vecs[5]  = '{"imiss",      0, 0, 0, 0, 0, 5'd0, 5'd0, 5'd0, 4'b1111, 4'b0001, 0};
        vecs[6]  = '{"branch",     1, 0, 0, 1, 0, 5'd0, 5'd0, 5'd0, 4'b1111, 4'b0011, 1};
        vecs[7]  = '{"br_over_lu", 1, 0, 0, 1, 1, 5'd8, 5'd2, 5'd8, 4'b1111, 4'b0011, 1};
        vecs[8]  = '{"dmiss",      1, 0, 1, 0, 0, 5'd0, 5'd0, 5'd0, 4'b0000, 4'b0000, 0};
        vecs[9]  = '{"dhit",       1, 1, 1, 0, 0, 5'd0, 5'd0, 5'd0, 4'b1111, 4'b0000, 1};
        vecs[10] = '{"dmiss_lu",   0, 0, 1, 0, 1, 5'd7, 5'd1, 5'd7, 4'b0000, 4'b0000, 0};
        vecs[11] = '{"lu_imiss",   0, 0, 0, 0, 1, 5'd1, 5'd6, 5'd6, 4'b1110, 4'b0010, 0};

        idle();
        RST = 1'b1;
        #1 check("reset_hold", 4'b0000, 4'b0000, 1'b0, 1'b0);
        step();
        RST = 1'b0;

        for (int i = 0; i < 12; i++) begin
            step();
            idle();
            ihit = vecs[i].ihit; dhit = vecs[i].dhit; mem_req = vecs[i].mem_req;
            br_taken = vecs[i].br_taken; ex_memread = vecs[i].ex_memread;
            id_rs = vecs[i].id_rs; id_rt = vecs[i].id_rt; ex_rd = vecs[i].ex_rd;
            #1 check(vecs[i].name, vecs[i].e_en, vecs[i].e_flush, vecs[i].e_pc, 1'b0);
        end

        // Data miss with branch arriving mid-freeze: redirect deferred until release.
        step(); idle(); mem_req = 1'b1;
        #1 check("dm_c1", 4'b0000, 4'b0000, 1'b0, 1'b0);
        step(); br_taken = 1'b1;
        #1 check("dm_c2_br", 4'b0000, 4'b0000, 1'b0, 1'b0);
        step(); br_taken = 1'b0;
        #1 check("dm_c3", 4'b0000, 4'b0000, 1'b0, 1'b0);
        step(); dhit = 1'b1;
        #1 check("dm_c4_redirect", 4'b1111, 4'b0011, 1'b1, 1'b0);
        step(); idle();
        #1 check("dm_c5", 4'b1111, 4'b0000, 1'b1, 1'b0);

        // Multi-cycle op: start cycle is default, then 3 stall cycles.
        step(); multi_start = 1'b1;
        #1 check("mc_start", 4'b1111, 4'b0000, 1'b1, 1'b0);
        for (int k = 0; k < 3; k++) begin
            step(); multi_start = 1'b0;
            #1 check($sformatf("mc_stall%0d", k), 4'b1100, 4'b0100, 1'b0, 1'b0);
        end
        step();
        #1 check("mc_done", 4'b1111, 4'b0000, 1'b1, 1'b0);

        // Multi-cycle op with a one-cycle dfreeze inside and a branch during the stall.
        step(); multi_start = 1'b1;
        #1 check("mcf_start", 4'b1111, 4'b0000, 1'b1, 1'b0);
        step(); multi_start = 1'b0; br_taken = 1'b1;
        #1 check("mcf_stall_br", 4'b1100, 4'b0100, 1'b0, 1'b0);
        step(); br_taken = 1'b0; mem_req = 1'b1;
        #1 check("mcf_freeze", 4'b0000, 4'b0000, 1'b0, 1'b0);
        step(); mem_req = 1'b0;
        #1 check("mcf_stall2", 4'b1100, 4'b0100, 1'b0, 1'b0);
        step();
        #1 check("mcf_stall3", 4'b1100, 4'b0100, 1'b0, 1'b0);
        step();
        #1 check("mcf_redirect", 4'b1111, 4'b0011, 1'b1, 1'b0);
        step();
        #1 check("mcf_done", 4'b1111, 4'b0000, 1'b1, 1'b0);

        // Reset mid-stall clears the counter immediately.
        step(); multi_start = 1'b1;
        step(); multi_start = 1'b0;
        #1 check("rs_stall", 4'b1100, 4'b0100, 1'b0, 1'b0);
        #1 RST = 1'b1;
        step(); RST = 1'b0;
        #1 check("rs_after", 4'b1111, 4'b0000, 1'b1, 1'b0);

        // Halt is sticky and dominates branch/ihit until async reset.
        step(); halt_in = 1'b1;
        #1 check("halt_in", 4'b1111, 4'b0000, 1'b1, 1'b0);
        step(); halt_in = 1'b0; br_taken = 1'b1;
        #1 check("halted_br", 4'b0000, 4'b0000, 1'b0, 1'b1);
        step(); br_taken = 1'b0; ihit = 1'b0;
        #1 check("halted_imiss", 4'b0000, 4'b0000, 1'b0, 1'b1);
        #1 RST = 1'b1;
        #1 check("halt_async_rst", 4'b0000, 4'b0000, 1'b0, 1'b0);
        step(); RST = 1'b0; idle();
        #1 check("post_rst_idle", 4'b1111, 4'b0000, 1'b1, 1'b0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
